// File: rtl/rst_quiesce_resp.sv
// rst_quiesce_resp: per-module reset responder that blocks and drains traffic, acks the RGU and holds local reset.
module rst_quiesce_resp #(
  parameter int OST_W       = 4,
  parameter int TIMEOUT_CNT = 256,
  parameter int HOLD_CNT    = 8
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic             rst_req_i,
  output logic             rst_ack_o,
  input  logic             txn_start_i,
  input  logic             txn_done_i,
  output logic             block_o,
  output logic             mod_rst_n_o,
  output logic [OST_W-1:0] ost_cnt_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);
  localparam int TW = $clog2(TIMEOUT_CNT + 1);
  localparam int HW = $clog2(HOLD_CNT + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, ACK, RELEASE} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;
  logic [OST_W-1:0] ost_nxt;
  always_comb
    ost_nxt = (txn_start_i && !txn_done_i) ? ((&ost_cnt_o) ? ost_cnt_o : ost_cnt_o + 1'b1) :
              (txn_done_i && !txn_start_i) ? ((ost_cnt_o == '0) ? ost_cnt_o : ost_cnt_o - 1'b1) :
              ost_cnt_o;
  assign state_o = state;
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rst_ack_o   <= 1'b0;
      block_o     <= 1'b0;
      mod_rst_n_o <= 1'b1;
      ost_cnt_o   <= '0;
      timeout_o   <= 1'b0;
      timer       <= '0;
      hold        <= '0;
    end else begin
      ost_cnt_o <= ost_nxt;
      case (state)
        IDLE:
          if (rst_req_i) begin
            state     <= DRAIN;
            block_o   <= 1'b1;
            timer     <= '0;
            timeout_o <= 1'b0;
          end
        DRAIN: begin
          timer <= timer + 1'b1;
          if (!rst_req_i) begin
            state   <= IDLE;
            block_o <= 1'b0;
          end else if (ost_nxt == '0 || timer == TW'(TIMEOUT_CNT - 1)) begin
            // in-flight transactions die with the module reset, so the count clears on entry
            state       <= ACK;
            rst_ack_o   <= 1'b1;
            mod_rst_n_o <= 1'b0;
            ost_cnt_o   <= '0;
            timeout_o   <= (ost_nxt != '0);
          end
        end
        ACK: begin
          ost_cnt_o <= '0;
          if (!rst_req_i) begin
            state     <= RELEASE;
            rst_ack_o <= 1'b0;
            hold      <= '0;
          end
        end
        RELEASE: begin
          hold <= hold + 1'b1;
          if (hold == HW'(HOLD_CNT - 1)) begin
            state       <= IDLE;
            mod_rst_n_o <= 1'b1;
            block_o     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rst_quiesce_resp.sv
// tb_rst_quiesce_resp: directed checks of drain, timeout, release, abort and counter edges.
module tb_rst_quiesce_resp;
  logic clk = 0;
  logic rst, req, ack, start, done, blk, mrst_n, tmo;
  logic [3:0] cnt;
  logic [1:0] st;
  int total = 0;
  int bad = 0;
  rst_quiesce_resp #(.OST_W(4), .TIMEOUT_CNT(16), .HOLD_CNT(8)) dut (
    .sys_clk_i(clk), .rst_i(rst), .rst_req_i(req), .rst_ack_o(ack),
    .txn_start_i(start), .txn_done_i(done), .block_o(blk), .mod_rst_n_o(mrst_n),
    .ost_cnt_o(cnt), .timeout_o(tmo), .state_o(st)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // drops req in ACK and walks RELEASE; rereq is presented during the last hold cycle
  task automatic release_seq(input string tag, input logic rereq);
    req = 0;
    tick();
    chk({tag, "_ack_drop"}, ack, 0);
    chk({tag, "_rel_state"}, st, 3);
    tick(7);
    chk({tag, "_hold_low"}, mrst_n, 0);
    chk({tag, "_hold_blk"}, blk, 1);
    req = rereq;
    tick();
    chk({tag, "_rel_mrst"}, mrst_n, 1);
    chk({tag, "_rel_blk"}, blk, 0);
    chk({tag, "_rel_idle"}, st, 0);
  endtask
  initial begin
    rst = 1; req = 0; start = 0; done = 0;
    tick(2);
    rst = 0;
    chk("rst_state", st, 0);
    chk("rst_ack", ack, 0);
    chk("rst_blk", blk, 0);
    chk("rst_mrst", mrst_n, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_tmo", tmo, 0);
    req = 1;
    tick();
    chk("idle_blk", blk, 1);
    chk("idle_drain", st, 1);
    tick();
    chk("idle_ack", ack, 1);
    chk("idle_mrst", mrst_n, 0);
    chk("idle_tmo", tmo, 0);
    release_seq("rel1", 1);
    tick();
    chk("rereq_drain", st, 1);
    chk("rereq_blk", blk, 1);
    tick();
    chk("rereq_ack", ack, 1);
    release_seq("rel2", 0);
    start = 1;
    tick(3);
    start = 0;
    chk("drain_cnt3", cnt, 3);
    req = 1;
    tick();
    chk("drain_state", st, 1);
    done = 1; tick(); done = 0;
    chk("drain_cnt2", cnt, 2);
    tick(3);
    done = 1; tick(); done = 0;
    chk("drain_cnt1", cnt, 1);
    chk("drain_still", st, 1);
    tick(2);
    done = 1; tick(); done = 0;
    chk("drain_ack_state", st, 2);
    chk("drain_ack", ack, 1);
    chk("drain_cnt0", cnt, 0);
    chk("drain_tmo", tmo, 0);
    release_seq("rel3", 0);
    start = 1;
    tick(2);
    start = 0;
    chk("to_cnt2", cnt, 2);
    req = 1;
    tick();
    tick(15);
    chk("to_still_drain", st, 1);
    chk("to_not_yet", tmo, 0);
    tick();
    chk("to_ack_state", st, 2);
    chk("to_tmo", tmo, 1);
    chk("to_cnt0", cnt, 0);
    release_seq("rel4", 0);
    chk("to_sticky", tmo, 1);
    start = 1; tick(); start = 0;
    chk("ab_cnt1", cnt, 1);
    req = 1;
    tick();
    chk("ab_drain", st, 1);
    chk("ab_tmo_clr", tmo, 0);
    req = 0;
    tick();
    chk("ab_idle", st, 0);
    chk("ab_blk", blk, 0);
    chk("ab_mrst", mrst_n, 1);
    chk("ab_ack", ack, 0);
    chk("ab_cnt", cnt, 1);
    start = 1; done = 1; tick();
    chk("both_cnt", cnt, 1);
    start = 0; tick();
    chk("done_cnt0", cnt, 0);
    tick();
    chk("done_at0", cnt, 0);
    done = 0; start = 1;
    tick(17);
    start = 0;
    chk("sat_cnt", cnt, 15);
    rst = 1; tick(); rst = 0;
    chk("rst_mid_cnt", cnt, 0);
    req = 1;
    tick(2);
    chk("rack_ack", ack, 1);
    rst = 1; tick(); rst = 0; req = 0;
    chk("rack_ack0", ack, 0);
    chk("rack_mrst", mrst_n, 1);
    chk("rack_state", st, 0);
    chk("rack_blk", blk, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
